// File: rtl/alu_scheduler_if.sv
// Signal bundle joining the requesters, alu_scheduler and the shared registered ALU.
// slave is the scheduler's view; master is the requester/ALU environment's view.
interface alu_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*3-1:0]      req_opcode;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;

  logic                      alu_enable;
  logic [2:0]                alu_opcode;
  logic [DATA_W-1:0]         alu_input1;
  logic [DATA_W-1:0]         alu_input2;
  logic [DATA_W-1:0]         alu_result;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_enable, alu_opcode, alu_input1, alu_input2,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_enable, alu_opcode, alu_input1, alu_input2,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one registered ALU between NUM_REQ requesters.
// Optional feature macro: ALU_SCHED_ILLEGAL_OP_EN (answer opcodes 5-7 with an error, never issue them).
module alu_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input logic           clock_in,
  input logic           reset_in,
  alu_scheduler_if.slave bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned OP_W = 3;
`ifdef ALU_SCHED_ILLEGAL_OP_EN
  localparam logic [OP_W-1:0] LAST_LEGAL_OP = OP_W'(4);
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              alu_enable_d;
  logic [OP_W-1:0]   alu_opcode_d;
  logic [DATA_W-1:0] alu_input1_d, alu_input2_d;
  logic              rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              rsp_err_d;

  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic              accept;
  int unsigned       cand;

  // Per-requester views of the packed request buses
  logic [OP_W-1:0]   op_arr [NUM_REQ];
  logic [DATA_W-1:0] a_arr  [NUM_REQ];
  logic [DATA_W-1:0] b_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i] = bus.req_opcode[i*OP_W +: OP_W];
    assign a_arr[i]  = bus.req_a[i*DATA_W +: DATA_W];
    assign b_arr[i]  = bus.req_b[i*DATA_W +: DATA_W];
  end

  // Round-robin search starting one past the last grant; ready only offered in IDLE
  always_comb begin
    grant_found   = 1'b0;
    grant_idx     = '0;
    cand          = 0;
    bus.req_ready = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_grant_q) + k) % NUM_REQ;
      if (!grant_found && bus.req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
    if (state_q == IDLE && !reset_in && grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = |(bus.req_valid & bus.req_ready);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    alu_enable_d = 1'b0;
    alu_opcode_d = bus.alu_opcode;
    alu_input1_d = bus.alu_input1;
    alu_input2_d = bus.alu_input2;
    rsp_valid_d  = bus.rsp_valid;
    rsp_id_d     = bus.rsp_id;
    rsp_data_d   = bus.rsp_data;
    rsp_err_d    = bus.rsp_err;

    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = grant_idx;
          id_d         = grant_idx;
`ifdef ALU_SCHED_ILLEGAL_OP_EN
          if (op_arr[grant_idx] > LAST_LEGAL_OP) begin
            // Skip the ALU entirely and answer straight away with an error
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d      = ISSUE;
            alu_enable_d = 1'b1;
            alu_opcode_d = op_arr[grant_idx];
            alu_input1_d = a_arr[grant_idx];
            alu_input2_d = b_arr[grant_idx];
            rsp_err_d    = 1'b0;
          end
`else
          state_d      = ISSUE;
          alu_enable_d = 1'b1;
          alu_opcode_d = op_arr[grant_idx];
          alu_input1_d = a_arr[grant_idx];
          alu_input2_d = b_arr[grant_idx];
          rsp_err_d    = 1'b0;
`endif
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = bus.alu_result;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q        <= IDLE;
      last_grant_q   <= ID_W'(NUM_REQ - 1);
      id_q           <= '0;
      bus.alu_enable <= 1'b0;
      bus.alu_opcode <= '0;
      bus.alu_input1 <= '0;
      bus.alu_input2 <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_data   <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      id_q           <= id_d;
      bus.alu_enable <= alu_enable_d;
      bus.alu_opcode <= alu_opcode_d;
      bus.alu_input1 <= alu_input1_d;
      bus.alu_input2 <= alu_input2_d;
      bus.rsp_valid  <= rsp_valid_d;
      bus.rsp_id     <= rsp_id_d;
      bus.rsp_data   <= rsp_data_d;
      bus.rsp_err    <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_alu_scheduler.sv
// Directed self-checking bench for alu_scheduler with a behavioural model of the shared ALU.
module tb_alu_scheduler;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;

  logic clock_in = 1'b0;
  logic reset_in;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] rr_data [5];
  int         rr_id   [5];

  alu_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  alu_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  // Registered ALU: 0 ADD, 1 SUB, 2 MUL, 3 GREATER_THAN, 4 EQUALS; other opcodes hold the output
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      bus.alu_result <= '0;
    end else if (bus.alu_enable) begin
      case (bus.alu_opcode)
        3'd0: bus.alu_result <= bus.alu_input1 + bus.alu_input2;
        3'd1: bus.alu_result <= bus.alu_input1 - bus.alu_input2;
        3'd2: bus.alu_result <= bus.alu_input1 * bus.alu_input2;
        3'd3: bus.alu_result <= {7'b0, ($signed(bus.alu_input1) > $signed(bus.alu_input2))};
        3'd4: bus.alu_result <= {7'b0, (bus.alu_input1 == bus.alu_input2)};
        default: bus.alu_result <= bus.alu_result;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    @(negedge clock_in);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_opcode[3*i +: 3] = op;
    bus.req_a[8*i +: 8]      = a;
    bus.req_b[8*i +: 8]      = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in       = 1'b1;
    bus.req_valid  = 4'b1111;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b1;

    // Reset held two cycles with every requester valid
    tick();
    tick();
    check("rst_req_ready",  32'(bus.req_ready),  32'h0);
    check("rst_alu_enable", 32'(bus.alu_enable), 32'h0);
    check("rst_alu_opcode", 32'(bus.alu_opcode), 32'h0);
    check("rst_alu_input1", 32'(bus.alu_input1), 32'h0);
    check("rst_alu_input2", 32'(bus.alu_input2), 32'h0);
    check("rst_rsp_valid",  32'(bus.rsp_valid),  32'h0);
    check("rst_rsp_id",     32'(bus.rsp_id),     32'h0);
    check("rst_rsp_data",   32'(bus.rsp_data),   32'h0);
    check("rst_rsp_err",    32'(bus.rsp_err),    32'h0);
    reset_in = 1'b0;
    #1;
    check("rst_first_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;

    // Single op: requester 2, ADD 100 + 27
    tick();
    set_req(2, 3'd0, 8'd100, 8'd27);
    bus.req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    check("single_en_t1",   32'(bus.alu_enable), 32'h1);
    check("single_op_t1",   32'(bus.alu_opcode), 32'h0);
    check("single_in1_t1",  32'(bus.alu_input1), 32'd100);
    check("single_in2_t1",  32'(bus.alu_input2), 32'd27);
    check("single_rv_t1",   32'(bus.rsp_valid),  32'h0);
    tick();
    check("single_en_t2",   32'(bus.alu_enable), 32'h0);
    check("single_rv_t2",   32'(bus.rsp_valid),  32'h0);
    tick();
    check("single_rv_t3",   32'(bus.rsp_valid),  32'h1);
    check("single_id_t3",   32'(bus.rsp_id),     32'h2);
    check("single_data_t3", 32'(bus.rsp_data),   32'd127);
    check("single_err_t3",  32'(bus.rsp_err),    32'h0);
    tick();
    check("single_rv_done", 32'(bus.rsp_valid),  32'h0);

    // Round-robin with all four requesters continuously valid, after a pointer reset
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    set_req(0, 3'd1, 8'd5,   8'd9);    // 5 - 9      = -4
    set_req(1, 3'd2, 8'd12,  8'd11);   // 12 * 11    = 132 -> -124
    set_req(2, 3'd0, 8'h9C,  8'hCE);   // -100 + -50 = -150 -> 106
    set_req(3, 3'd4, 8'd3,   8'd3);    // 3 == 3     = 1
    rr_id   = '{0, 1, 2, 3, 0};
    rr_data = '{8'hFC, 8'h84, 8'h6A, 8'h01, 8'hFC};
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1;
      check("rr_ready", 32'(bus.req_ready), 32'(1 << rr_id[g]));
      tick();
      tick();
      tick();
      check("rr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("rr_rsp_id",    32'(bus.rsp_id),    32'(rr_id[g]));
      check("rr_rsp_data",  32'(bus.rsp_data),  32'(rr_data[g]));
      tick();
    end
    bus.req_valid = '0;

    // Backpressure: GREATER_THAN -3 > 2 from requester 1 while requester 2 waits
    set_req(1, 3'd3, 8'hFD, 8'd2);
    set_req(2, 3'd0, 8'd1,  8'd2);
    bus.req_valid = 4'b0110;
    bus.rsp_ready = 1'b0;
    #1;
    check("bp_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0100;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_hold_data",  32'(bus.rsp_data),  32'h0);
      check("bp_hold_ready", 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_rsp_id", 32'(bus.rsp_id), 32'h1);
    tick();
    check("bp_after_valid", 32'(bus.rsp_valid), 32'h0);
    check("bp_after_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    check("bp_next_valid", 32'(bus.rsp_valid), 32'h1);
    check("bp_next_id",    32'(bus.rsp_id),    32'h2);
    check("bp_next_data",  32'(bus.rsp_data),  32'd3);
    tick();

    // Reset during CAPTURE of EQUALS 7 == 7 from requester 1
    set_req(1, 3'd4, 8'd7, 8'd7);
    bus.req_valid = 4'b0010;
    #1;
    check("mid_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    check("mid_en", 32'(bus.alu_enable), 32'h1);
    tick();
    reset_in = 1'b1;
    tick();
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("mid_req_ready", 32'(bus.req_ready), 32'h0);
    reset_in = 1'b0;
    set_req(0, 3'd0, 8'd7, 8'd7);
    set_req(2, 3'd1, 8'd9, 8'd4);
    bus.req_valid = 4'b0101;
    #1;
    check("mid_ptr_ready", 32'(bus.req_ready), 32'h1);
    check("mid_no_rsp",    32'(bus.rsp_valid), 32'h0);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    check("mid_next_valid", 32'(bus.rsp_valid), 32'h1);
    check("mid_next_id",    32'(bus.rsp_id),    32'h0);
    check("mid_next_data",  32'(bus.rsp_data),  32'd14);
    tick();

    // Opcode 6 from requester 1
    set_req(1, 3'd6, 8'd20, 8'd30);
    bus.req_valid = 4'b0010;
    #1;
    check("ill_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
`ifdef ALU_SCHED_ILLEGAL_OP_EN
    check("ill_rsp_valid", 32'(bus.rsp_valid),  32'h1);
    check("ill_rsp_err",   32'(bus.rsp_err),    32'h1);
    check("ill_rsp_data",  32'(bus.rsp_data),   32'h0);
    check("ill_rsp_id",    32'(bus.rsp_id),     32'h1);
    check("ill_en_t1",     32'(bus.alu_enable), 32'h0);
    tick();
    check("ill_en_t2",     32'(bus.alu_enable), 32'h0);
    check("ill_done",      32'(bus.rsp_valid),  32'h0);
`else
    check("ill_en_t1",     32'(bus.alu_enable), 32'h1);
    check("ill_op_t1",     32'(bus.alu_opcode), 32'h6);
    tick();
    tick();
    check("ill_rsp_valid", 32'(bus.rsp_valid),  32'h1);
    check("ill_rsp_err",   32'(bus.rsp_err),    32'h0);
    check("ill_rsp_id",    32'(bus.rsp_id),     32'h1);
    check("ill_rsp_data",  32'(bus.rsp_data),   32'd14);
    tick();
    check("ill_done",      32'(bus.rsp_valid),  32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
